// File: rtl/serv_rf_ram_bridge.sv
// serv_rf_ram_bridge
// Bridges the bit-serial register file ports of a SERV-style core onto a
// 2-bit wide RAM that has separate read and write ports. Reads fetch two
// registers interleaved word by word and serialize them LSB first. Writes
// collect two serial streams into 2-bit words and emit one strobe per word.
//
// Optional build feature:
//   SERV_RF_X0_ZERO_EN  when defined, register 0 reads back as zero and is
//                       never written. When undefined, register 0 is an
//                       ordinary address.
module serv_rf_ram_bridge #(
    parameter int WITH_CSR = 1
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_rreq,
    input  logic                  i_wreq,
    output logic                  o_ready,
    input  logic [4+WITH_CSR:0]   i_rreg0,
    input  logic [4+WITH_CSR:0]   i_rreg1,
    output logic                  o_rdata0,
    output logic                  o_rdata1,
    input  logic [4+WITH_CSR:0]   i_wreg0,
    input  logic [4+WITH_CSR:0]   i_wreg1,
    input  logic                  i_wen0,
    input  logic                  i_wen1,
    input  logic                  i_wdata0,
    input  logic                  i_wdata1,
    output logic [8+WITH_CSR:0]   o_raddr,
    output logic [8+WITH_CSR:0]   o_waddr,
    output logic [1:0]            o_wdata,
    output logic                  o_wen,
    input  logic [1:0]            i_rdata
);

    localparam int RW = 5 + WITH_CSR;
    localparam int AW = 9 + WITH_CSR;

    // ------------------------------------------------------------------
    // Read side state
    // ------------------------------------------------------------------
    logic          ractive_q, ractive_d;   // address counter running
    logic [4:0]    rcnt_q, rcnt_d;         // address phase 0..31
    logic          racc_q, racc_d;         // read accepted last cycle
    logic          rvld1_q, rvld1_d;       // RAM data valid this cycle
    logic [4:0]    rcnt1_q, rcnt1_d;       // phase that produced i_rdata
    logic          rzero1_q, rzero1_d;     // i_rdata belongs to register 0
    logic          rd0_q, rd0_d;           // serial output for port 0
    logic          rd0_hi_q, rd0_hi_d;     // upper bit of port 0 word
    logic          rd1_hi_q, rd1_hi_d;     // upper bit of port 1 word
    logic          rd1_hi_vld_q, rd1_hi_vld_d;

    logic          rstart_s;
    logic [RW-1:0] rsel_reg_s;
    logic          rzero_s;
    logic [1:0]    rword_s;

    // ------------------------------------------------------------------
    // Write side state
    // ------------------------------------------------------------------
    logic          wgo_q, wgo_d;           // write accepted last cycle
    logic          wactive_q, wactive_d;   // serial bits arriving
    logic [4:0]    wcnt_q, wcnt_d;         // bit index 0..31
    logic          wlo0_q, wlo0_d;         // even bit of port 0 word
    logic          wlo1_q, wlo1_d;         // even bit of port 1 word
    logic          wen_q, wen_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [1:0]    wdata_q, wdata_d;
    logic          p1_pend_q, p1_pend_d;   // port 1 word waiting one cycle
    logic          p1_wen_q, p1_wen_d;
    logic [AW-1:0] p1_addr_q, p1_addr_d;
    logic [1:0]    p1_data_q, p1_data_d;

    logic          wbusy_s;
    logic          wstart_s;
    logic          wok0_s;
    logic          wok1_s;

    logic          ready_q, ready_d;

    // ------------------------------------------------------------------
    // Register 0 handling
    // ------------------------------------------------------------------
`ifdef SERV_RF_X0_ZERO_EN
    assign rzero_s = (rsel_reg_s == {RW{1'b0}});
    assign wok0_s  = (i_wreg0 != {RW{1'b0}});
    assign wok1_s  = (i_wreg1 != {RW{1'b0}});
`else
    assign rzero_s = 1'b0;
    assign wok0_s  = 1'b1;
    assign wok1_s  = 1'b1;
`endif

    // Even phases address rs1, odd phases rs2; word index is the upper phase bits.
    assign rsel_reg_s = rcnt_q[0] ? i_rreg1 : i_rreg0;
    assign o_raddr    = {rsel_reg_s, rcnt_q[4:1]};

    // Returned word, forced to zero when it came from a protected register.
    assign rword_s = rzero1_q ? 2'b00 : i_rdata;

    // Read address counter: starts on an accepted request, parks after phase 31.
    always_comb begin
        rstart_s  = i_rreq & ~ractive_q;
        ractive_d = ractive_q;
        rcnt_d    = rcnt_q;
        racc_d    = rstart_s;
        if (rstart_s) begin
            ractive_d = 1'b1;
            rcnt_d    = 5'd0;
        end else if (ractive_q) begin
            if (rcnt_q == 5'd31) begin
                ractive_d = 1'b0;
                rcnt_d    = rcnt_q;
            end else begin
                ractive_d = 1'b1;
                rcnt_d    = rcnt_q + 5'd1;
            end
        end else begin
            ractive_d = 1'b0;
            rcnt_d    = rcnt_q;
        end
    end

    // Read data serializer: port 0 is fully registered; port 1 forwards the
    // low bit of its word in the cycle it arrives and replays the high bit next.
    always_comb begin
        rvld1_d      = ractive_q;
        rcnt1_d      = rcnt_q;
        rzero1_d     = rzero_s;
        rd0_d        = 1'b0;
        rd0_hi_d     = rd0_hi_q;
        rd1_hi_d     = rd1_hi_q;
        rd1_hi_vld_d = 1'b0;
        if (rvld1_q) begin
            if (!rcnt1_q[0]) begin
                rd0_d    = rword_s[0];
                rd0_hi_d = rword_s[1];
            end else begin
                rd0_d        = rd0_hi_q;
                rd1_hi_d     = rword_s[1];
                rd1_hi_vld_d = 1'b1;
            end
        end else begin
            rd0_d        = 1'b0;
            rd1_hi_vld_d = 1'b0;
        end
    end

    assign o_rdata0 = rd0_q;
    assign o_rdata1 = (rvld1_q & rcnt1_q[0]) ? rword_s[0] : (rd1_hi_vld_q & rd1_hi_q);

    // Read side registers.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ractive_q    <= 1'b0;
            rcnt_q       <= 5'd0;
            racc_q       <= 1'b0;
            rvld1_q      <= 1'b0;
            rcnt1_q      <= 5'd0;
            rzero1_q     <= 1'b0;
            rd0_q        <= 1'b0;
            rd0_hi_q     <= 1'b0;
            rd1_hi_q     <= 1'b0;
            rd1_hi_vld_q <= 1'b0;
        end else begin
            ractive_q    <= ractive_d;
            rcnt_q       <= rcnt_d;
            racc_q       <= racc_d;
            rvld1_q      <= rvld1_d;
            rcnt1_q      <= rcnt1_d;
            rzero1_q     <= rzero1_d;
            rd0_q        <= rd0_d;
            rd0_hi_q     <= rd0_hi_d;
            rd1_hi_q     <= rd1_hi_d;
            rd1_hi_vld_q <= rd1_hi_vld_d;
        end
    end

    // Write bit counter: one idle cycle after the request, then 32 bit slots.
    always_comb begin
        wbusy_s   = wgo_q | wactive_q;
        wstart_s  = i_wreq & ~wbusy_s;
        wgo_d     = wstart_s;
        wactive_d = wactive_q;
        wcnt_d    = wcnt_q;
        if (wgo_q) begin
            wactive_d = 1'b1;
            wcnt_d    = 5'd0;
        end else if (wactive_q) begin
            if (wcnt_q == 5'd31) begin
                wactive_d = 1'b0;
                wcnt_d    = wcnt_q;
            end else begin
                wactive_d = 1'b1;
                wcnt_d    = wcnt_q + 5'd1;
            end
        end else begin
            wactive_d = 1'b0;
            wcnt_d    = wcnt_q;
        end
    end

    // Write word assembly: port 0 word goes out right after its odd bit,
    // port 1 word is parked one cycle so the two never share a strobe.
    always_comb begin
        wlo0_d    = wlo0_q;
        wlo1_d    = wlo1_q;
        wen_d     = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        p1_pend_d = 1'b0;
        p1_wen_d  = p1_wen_q;
        p1_addr_d = p1_addr_q;
        p1_data_d = p1_data_q;
        if (wactive_q && !wcnt_q[0]) begin
            wlo0_d = i_wdata0;
            wlo1_d = i_wdata1;
        end else if (wactive_q && wcnt_q[0]) begin
            wen_d     = i_wen0 & wok0_s;
            waddr_d   = {i_wreg0, wcnt_q[4:1]};
            wdata_d   = {i_wdata0, wlo0_q};
            p1_pend_d = 1'b1;
            p1_wen_d  = i_wen1 & wok1_s;
            p1_addr_d = {i_wreg1, wcnt_q[4:1]};
            p1_data_d = {i_wdata1, wlo1_q};
        end else begin
            wlo0_d = wlo0_q;
            wlo1_d = wlo1_q;
        end
        if (p1_pend_q) begin
            wen_d   = p1_wen_q;
            waddr_d = p1_addr_q;
            wdata_d = p1_data_q;
        end else begin
            p1_wen_d = p1_wen_d;
        end
    end

    assign o_wen   = wen_q;
    assign o_waddr = waddr_q;
    assign o_wdata = wdata_q;

    // Write side registers.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wgo_q     <= 1'b0;
            wactive_q <= 1'b0;
            wcnt_q    <= 5'd0;
            wlo0_q    <= 1'b0;
            wlo1_q    <= 1'b0;
            wen_q     <= 1'b0;
            waddr_q   <= {AW{1'b0}};
            wdata_q   <= 2'b00;
            p1_pend_q <= 1'b0;
            p1_wen_q  <= 1'b0;
            p1_addr_q <= {AW{1'b0}};
            p1_data_q <= 2'b00;
        end else begin
            wgo_q     <= wgo_d;
            wactive_q <= wactive_d;
            wcnt_q    <= wcnt_d;
            wlo0_q    <= wlo0_d;
            wlo1_q    <= wlo1_d;
            wen_q     <= wen_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            p1_pend_q <= p1_pend_d;
            p1_wen_q  <= p1_wen_d;
            p1_addr_q <= p1_addr_d;
            p1_data_q <= p1_data_d;
        end
    end

    // Acknowledge: writes one cycle after request, reads two cycles after.
    always_comb begin
        ready_d = wstart_s | racc_q;
    end

    assign o_ready = ready_q;

    // Acknowledge register.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= ready_d;
        end
    end

endmodule

// File: tb/tb_serv_rf_ram_bridge.sv
// Directed, table-driven bench for serv_rf_ram_bridge with a 2-bit RAM model.
// Expectations for register 0 follow SERV_RF_X0_ZERO_EN when it is defined.
module tb_serv_rf_ram_bridge;

    localparam int WITH_CSR = 1;
    localparam int RW   = 5 + WITH_CSR;
    localparam int AW   = 9 + WITH_CSR;
    localparam int NCYC = 48;

`ifdef SERV_RF_X0_ZERO_EN
    localparam logic [31:0] X0_PRE  = 32'h0000_0000;
    localparam logic [31:0] X0_POST = 32'h0000_0000;
    localparam logic [63:0] X0_WEN  = 64'h0000_0000_0000_0000;
`else
    localparam logic [31:0] X0_PRE  = 32'hCAFE_F00D;
    localparam logic [31:0] X0_POST = 32'hFFFF_FFFF;
    localparam logic [63:0] X0_WEN  = 64'h0000_0005_5555_5550;
`endif

    logic          clk = 1'b0;
    logic          i_rst_n;
    logic          i_rreq, i_wreq, o_ready;
    logic [RW-1:0] i_rreg0, i_rreg1, i_wreg0, i_wreg1;
    logic          o_rdata0, o_rdata1;
    logic          i_wen0, i_wen1, i_wdata0, i_wdata1;
    logic [AW-1:0] o_raddr, o_waddr;
    logic [1:0]    o_wdata, ram_rdata;
    logic          o_wen;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serv_rf_ram_bridge #(.WITH_CSR(WITH_CSR)) dut (
        .clk(clk), .i_rst_n(i_rst_n),
        .i_rreq(i_rreq), .i_wreq(i_wreq), .o_ready(o_ready),
        .i_rreg0(i_rreg0), .i_rreg1(i_rreg1),
        .o_rdata0(o_rdata0), .o_rdata1(o_rdata1),
        .i_wreg0(i_wreg0), .i_wreg1(i_wreg1),
        .i_wen0(i_wen0), .i_wen1(i_wen1),
        .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
        .o_raddr(o_raddr), .o_waddr(o_waddr),
        .o_wdata(o_wdata), .o_wen(o_wen),
        .i_rdata(ram_rdata)
    );

    // RAM model: one-cycle read latency, bench preload port has priority.
    logic [1:0]    mem [0:(1<<AW)-1];
    logic          pl_we;
    logic [AW-1:0] pl_addr;
    logic [1:0]    pl_d;
    always @(posedge clk) begin
        ram_rdata <= mem[o_raddr];
        if (pl_we) mem[pl_addr] <= pl_d;
        else if (o_wen) mem[o_waddr] <= o_wdata;
    end

    typedef struct {
        string       name;
        int          rs;
        int          rs2;
        logic [5:0]  rreg0, rreg1;
        int          ws;
        logic [5:0]  wreg0, wreg1;
        logic [31:0] wd0, wd1;
        logic        wen0, wen1;
        int          rst_cyc;
        logic [63:0] exp_ready, exp_wen;
        logic [31:0] exp_r0, exp_r1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string nm, input int rs, input int rs2,
                                input logic [5:0] rr0, input logic [5:0] rr1,
                                input int ws, input logic [5:0] wr0, input logic [5:0] wr1,
                                input logic [31:0] wd0, input logic [31:0] wd1,
                                input logic we0, input logic we1, input int rst,
                                input logic [63:0] er, input logic [63:0] ew,
                                input logic [31:0] e0, input logic [31:0] e1);
        vec_t v;
        v.name = nm; v.rs = rs; v.rs2 = rs2; v.rreg0 = rr0; v.rreg1 = rr1;
        v.ws = ws; v.wreg0 = wr0; v.wreg1 = wr1; v.wd0 = wd0; v.wd1 = wd1;
        v.wen0 = we0; v.wen1 = we1; v.rst_cyc = rst;
        v.exp_ready = er; v.exp_wen = ew; v.exp_r0 = e0; v.exp_r1 = e1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [5:0] r, input logic [31:0] val);
        for (int k = 0; k < 16; k++) begin
            pl_we   = 1'b1;
            pl_addr = {r, k[3:0]};
            pl_d    = val[2*k +: 2];
            @(posedge clk); #1;
        end
        pl_we = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [63:0] rdy_m, wen_m;
        logic [31:0] g0, g1;
        int stray, n;
        rdy_m = 64'd0; wen_m = 64'd0; g0 = 32'd0; g1 = 32'd0; stray = 0;
        i_rreg0 = v.rreg0; i_rreg1 = v.rreg1;
        i_wreg0 = v.wreg0; i_wreg1 = v.wreg1;
        for (int c = 0; c < NCYC; c++) begin
            i_rreq = (c == v.rs) || (c == v.rs2);
            i_wreq = (c == v.ws);
            n = c - (v.ws + 2);
            if (v.ws >= 0 && n >= 0 && n < 32) begin
                i_wdata0 = v.wd0[n]; i_wdata1 = v.wd1[n];
                i_wen0 = v.wen0; i_wen1 = v.wen1;
            end else begin
                i_wdata0 = 1'b0; i_wdata1 = 1'b0; i_wen0 = 1'b0; i_wen1 = 1'b0;
            end
            if (c == v.rst_cyc) i_rst_n = 1'b0;
            @(negedge clk);
            if (c == v.rst_cyc)
                chk({v.name, "_rst_outs"}, {60'd0, o_ready, o_wen, o_rdata0, o_rdata1}, 64'd0);
            rdy_m[c] = o_ready;
            wen_m[c] = o_wen;
            if (v.rs >= 0 && c >= v.rs + 3 && c <= v.rs + 34) begin
                g0[c - v.rs - 3] = o_rdata0;
                g1[c - v.rs - 3] = o_rdata1;
            end else if (o_rdata0 || o_rdata1) begin
                stray++;
            end
            @(posedge clk); #1;
            if (c == v.rst_cyc) i_rst_n = 1'b1;
        end
        i_rreq = 1'b0; i_wreq = 1'b0;
        chk({v.name, "_ready"}, rdy_m, v.exp_ready);
        chk({v.name, "_wen"}, wen_m, v.exp_wen);
        chk({v.name, "_rdata_idle"}, 64'(stray), 64'd0);
        if (v.rs >= 0) begin
            chk({v.name, "_rdata0"}, {32'd0, g0}, {32'd0, v.exp_r0});
            chk({v.name, "_rdata1"}, {32'd0, g1}, {32'd0, v.exp_r1});
        end
    endtask

    // Acknowledge pattern for retriggered requests; enables stay low.
    task automatic seq(input string nm, input int r1, input int r2,
                       input int w1, input int w2, input logic [63:0] exp);
        logic [63:0] m;
        m = 64'd0;
        i_wen0 = 1'b0; i_wen1 = 1'b0; i_wdata0 = 1'b0; i_wdata1 = 1'b0;
        i_rreg0 = 6'd5; i_rreg1 = 6'd6; i_wreg0 = 6'd13; i_wreg1 = 6'd13;
        for (int c = 0; c < 40; c++) begin
            i_rreq = (c == r1) || (c == r2);
            i_wreq = (c == w1) || (c == w2);
            @(negedge clk);
            m[c] = o_ready;
            @(posedge clk); #1;
        end
        i_rreq = 1'b0; i_wreq = 1'b0;
        repeat (40) begin @(posedge clk); #1; end
        chk(nm, m, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        i_rst_n = 1'b0; i_rreq = 1'b0; i_wreq = 1'b0;
        i_rreg0 = 6'd0; i_rreg1 = 6'd0; i_wreg0 = 6'd0; i_wreg1 = 6'd0;
        i_wen0 = 1'b0; i_wen1 = 1'b0; i_wdata0 = 1'b0; i_wdata1 = 1'b0;
        pl_we = 1'b0; pl_addr = {AW{1'b0}}; pl_d = 2'b00;
        #2;
        chk("reset_outs", {60'd0, o_ready, o_wen, o_rdata0, o_rdata1}, 64'd0);
        @(posedge clk); #1;
        i_rst_n = 1'b1;

        preload(6'd0,  32'hCAFE_F00D);
        preload(6'd5,  32'hDEAD_BEEF);
        preload(6'd6,  32'h1234_5678);
        preload(6'd7,  32'h1111_1111);
        preload(6'd8,  32'h2222_2222);
        preload(6'd9,  32'h0BAD_F00D);
        preload(6'd10, 32'h600D_CAFE);
        preload(6'd11, 32'h1357_9BDF);
        preload(6'd12, 32'h8765_4321);
        preload(6'd13, 32'h0000_0000);
        preload(6'd14, 32'h0000_0000);
        preload(6'd15, 32'h0000_0000);

        //                name          rs  rs2 rreg0  rreg1  ws  wreg0  wreg1  wd0            wd1            we0   we1   rst  ready                  wen                     r0             r1
        vecs.push_back(mk("rd_x5_x6",    0,  -1, 6'd5,  6'd6,  -1, 6'd0,  6'd0,  32'h0,         32'h0,         1'b0, 1'b0, -1, 64'h4,    64'h0,                  32'hDEAD_BEEF, 32'h1234_5678));
        vecs.push_back(mk("wr_x7",      -1,  -1, 6'd0,  6'd0,   0, 6'd7,  6'd12, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 1'b1, 1'b0, -1, 64'h2,    64'h0000_0005_5555_5550, 32'h0,        32'h0));
        vecs.push_back(mk("rd_x7_x12",   0,  -1, 6'd7,  6'd12, -1, 6'd0,  6'd0,  32'h0,         32'h0,         1'b0, 1'b0, -1, 64'h4,    64'h0,                  32'hA5A5_A5A5, 32'h8765_4321));
        vecs.push_back(mk("overlap",    10,  -1, 6'd9,  6'd10,  0, 6'd8,  6'd13, 32'h0000_FFFF, 32'h3C3C_3C3C, 1'b1, 1'b1, -1, 64'h1002, 64'h0000_000F_FFFF_FFF0, 32'h0BAD_F00D, 32'h600D_CAFE));
        vecs.push_back(mk("rd_x8_x13",   0,  -1, 6'd8,  6'd13, -1, 6'd0,  6'd0,  32'h0,         32'h0,         1'b0, 1'b0, -1, 64'h4,    64'h0,                  32'h0000_FFFF, 32'h3C3C_3C3C));
        vecs.push_back(mk("same_cycle",  0,   5, 6'd5,  6'd6,   0, 6'd14, 6'd15, 32'h5A5A_0F0F, 32'hF00F_F00F, 1'b1, 1'b1, -1, 64'h6,    64'h0000_000F_FFFF_FFF0, 32'hDEAD_BEEF, 32'h1234_5678));
        vecs.push_back(mk("rd_x14_x15",  0,  -1, 6'd14, 6'd15, -1, 6'd0,  6'd0,  32'h0,         32'h0,         1'b0, 1'b0, -1, 64'h4,    64'h0,                  32'h5A5A_0F0F, 32'hF00F_F00F));
        vecs.push_back(mk("rst_mid_wr", -1,  -1, 6'd0,  6'd0,   0, 6'd11, 6'd12, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 10, 64'h2,    64'h150,                32'h0,         32'h0));
        vecs.push_back(mk("rd_x11_x12",  0,  -1, 6'd11, 6'd12, -1, 6'd0,  6'd0,  32'h0,         32'h0,         1'b0, 1'b0, -1, 64'h4,    64'h0,                  32'h1357_9BC0, 32'h8765_4321));
        vecs.push_back(mk("rd_x0_pre",   0,  -1, 6'd0,  6'd5,  -1, 6'd0,  6'd0,  32'h0,         32'h0,         1'b0, 1'b0, -1, 64'h4,    64'h0,                  X0_PRE,        32'hDEAD_BEEF));
        vecs.push_back(mk("wr_x0",      -1,  -1, 6'd0,  6'd0,   0, 6'd0,  6'd0,  32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0, -1, 64'h2,    X0_WEN,                 32'h0,         32'h0));
        vecs.push_back(mk("rd_x0_post",  0,  -1, 6'd0,  6'd5,  -1, 6'd0,  6'd0,  32'h0,         32'h0,         1'b0, 1'b0, -1, 64'h4,    64'h0,                  X0_POST,       32'hDEAD_BEEF));

        foreach (vecs[i]) begin
            run_vec(vecs[i]);
        end

        seq("rd_retrig_busy", 0, 32, -1, -1, 64'h0000_0000_0000_0004);
        seq("rd_retrig_free", 0, 33, -1, -1, 64'h0000_0008_0000_0004);
        seq("wr_retrig_busy", -1, -1, 0, 20, 64'h0000_0000_0000_0002);
        seq("wr_retrig_free", -1, -1, 0, 34, 64'h0000_0008_0000_0002);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
